// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two CPU stages: the upstream entry (payload, PC, exception codes)
// and the downstream head. slave = the stage buffer, master = whoever drives and consumes it.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic [EXC_W-1:0]  in_exc;
  logic [EXC_W-1:0]  local_exc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [EXC_W-1:0]  out_exc;

  // Valid/ready: a transfer happens on a rising edge where both valid and ready are high.
  // A valid side holds its payload stable until that edge; ready may change freely.
  modport slave (
    input  in_valid, in_data, in_pc, in_exc, local_exc, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_exc
  );

  modport master (
    output in_valid, in_data, in_pc, in_exc, local_exc, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_exc
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register carrying payload, PC and merged exception code between two stages,
// with optional 2-entry skid buffer (SKID=1), flush and interrupt kill.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int SKID   = 1
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_buf_if.slave    bus,
  input  logic               flush,
  input  logic               kill,
  output logic [1:0]         count
);

  logic              r_head_v;
  logic [DATA_W-1:0] r_head_data;
  logic [PC_W-1:0]   r_head_pc;
  logic [EXC_W-1:0]  r_head_exc;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_skid_pc;
  logic [EXC_W-1:0]  r_skid_exc;
  logic [1:0]        r_count;

  logic              w_acc;
  logic              w_pop;
  logic [EXC_W-1:0]  w_exc;

  // Older exception (from earlier stages) wins over one detected here.
  assign w_exc = (bus.in_exc != '0) ? bus.in_exc : bus.local_exc;

  // With the skid buffer, in_ready comes straight from the occupancy register so it
  // has no combinational path from out_ready.
  assign bus.in_ready = (SKID != 0) ? (r_count != 2'd2) : (!r_head_v || bus.out_ready);

  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_pop = r_head_v && bus.out_ready;

  assign bus.out_valid = r_head_v;
  assign bus.out_data  = r_head_data;
  assign bus.out_pc    = r_head_pc;
  assign bus.out_exc   = r_head_exc;
  assign count         = r_count;

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      r_head_v    <= 1'b0;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_head_exc  <= '0;
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
      r_skid_exc  <= '0;
      r_count     <= 2'd0;
    end else if (flush) begin
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_acc} - {1'b0, w_pop};
      if (SKID != 0) begin
        if (w_pop && r_skid_v) begin
          // Skid full means in_ready is low, so nothing new arrives on this edge.
          r_head_data <= r_skid_data;
          r_head_pc   <= r_skid_pc;
          r_head_exc  <= r_skid_exc;
          r_skid_v    <= 1'b0;
        end else if (w_pop || !r_head_v) begin
          r_head_v <= w_acc;
          if (w_acc) begin
            r_head_data <= bus.in_data;
            r_head_pc   <= bus.in_pc;
            r_head_exc  <= w_exc;
          end
        end else if (w_acc) begin
          r_skid_v    <= 1'b1;
          r_skid_data <= bus.in_data;
          r_skid_pc   <= bus.in_pc;
          r_skid_exc  <= w_exc;
        end
      end else begin
        if (w_acc) begin
          r_head_v    <= 1'b1;
          r_head_data <= bus.in_data;
          r_head_pc   <= bus.in_pc;
          r_head_exc  <= w_exc;
        end else if (w_pop) begin
          r_head_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=0 and one SKID=1 instance share the same stimulus and
// are each compared against a queue-based model of the stage.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_exc = '0;
  logic [4:0]  local_exc = '0;
  logic [1:0]  count0;
  logic [1:0]  count1;

  int checks = 0;
  int failures = 0;

  ent_t q0[$];
  ent_t q1[$];
  ent_t hold0 = '0;
  ent_t hold1 = '0;
  bit   hk0 = 1'b0;
  bit   hk1 = 1'b0;

  pipe_stage_buf_if #(.DATA_W(32), .PC_W(32), .EXC_W(5)) bus0 ();
  pipe_stage_buf_if #(.DATA_W(32), .PC_W(32), .EXC_W(5)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_pc     = in_pc;
  assign bus0.in_exc    = in_exc;
  assign bus0.local_exc = local_exc;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_pc     = in_pc;
  assign bus1.in_exc    = in_exc;
  assign bus1.local_exc = local_exc;
  assign bus1.out_ready = out_ready;

  pipe_stage_buf #(.DATA_W(32), .PC_W(32), .EXC_W(5), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .flush(flush), .kill(kill), .count(count0)
  );

  pipe_stage_buf #(.DATA_W(32), .PC_W(32), .EXC_W(5), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .flush(flush), .kill(kill), .count(count1)
  );

  always #5 clk = ~clk;

  function automatic bit exp_rdy0();
    return (q0.size() == 0) || out_ready;
  endfunction

  function automatic bit exp_rdy1();
    return q1.size() < 2;
  endfunction

  // One rising edge: the model decides accept/pop from pre-edge state, then applies
  // reset > kill > flush > normal. Returns 1 time unit after the edge.
  task automatic cycle();
    bit   acc0, acc1, pop0, pop1;
    ent_t e;
    e.d   = in_data;
    e.pc  = in_pc;
    e.exc = (in_exc != 0) ? in_exc : local_exc;
    acc0 = in_valid && exp_rdy0();
    acc1 = in_valid && exp_rdy1();
    pop0 = (q0.size() != 0) && out_ready;
    pop1 = (q1.size() != 0) && out_ready;
    @(posedge clk);
    if (reset || kill) begin
      q0.delete(); q1.delete();
      hold0 = '0; hold1 = '0; hk0 = 1'b1; hk1 = 1'b1;
    end else if (flush) begin
      q0.delete(); q1.delete();
      hk0 = 1'b0; hk1 = 1'b0;
    end else begin
      if (pop0) begin hold0 = q0.pop_front(); hk0 = 1'b1; end
      if (acc0) q0.push_back(e);
      if (pop1) begin hold1 = q1.pop_front(); hk1 = 1'b1; end
      if (acc1) q1.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    hold0 = '0; hold1 = '0; hk0 = 1'b1; hk1 = 1'b1;
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%b exp=0", bus0.out_valid); end
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", bus1.out_valid); end
    checks++; if ({bus0.out_data, bus0.out_pc, bus0.out_exc} !== 69'd0) begin failures++; $display("FAIL reset_payload0 got=%h exp=0", {bus0.out_data, bus0.out_pc, bus0.out_exc}); end
    checks++; if ({bus1.out_data, bus1.out_pc, bus1.out_exc} !== 69'd0) begin failures++; $display("FAIL reset_payload1 got=%h exp=0", {bus1.out_data, bus1.out_pc, bus1.out_exc}); end
    checks++; if (count0 !== 2'd0 || count1 !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", count0, count1); end
    checks++; if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", bus0.in_ready, bus1.in_ready); end
  endtask

  task automatic test_first_accept();
    in_valid = 1'b1; in_data = 32'h1234_5678; in_pc = 32'h3000; in_exc = 5'd0; local_exc = 5'd0; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (bus1.out_valid !== 1'b1 || bus0.out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b/%b exp=1/1", bus0.out_valid, bus1.out_valid); end
    checks++; if (bus1.out_data !== 32'h1234_5678 || bus0.out_data !== 32'h1234_5678) begin failures++; $display("FAIL first_data got=%h/%h exp=12345678", bus0.out_data, bus1.out_data); end
    checks++; if (bus1.out_pc !== 32'h3000 || bus0.out_pc !== 32'h3000) begin failures++; $display("FAIL first_pc got=%h/%h exp=3000", bus0.out_pc, bus1.out_pc); end
    checks++; if (count1 !== 2'd1 || count0 !== 2'd1) begin failures++; $display("FAIL first_count got=%0d/%0d exp=1/1", count0, count1); end
    cycle();
    checks++; if (bus1.out_valid !== 1'b0 || bus1.out_data !== 32'h1234_5678) begin failures++; $display("FAIL bubble_hold got=%b,%h exp=0,12345678", bus1.out_valid, bus1.out_data); end
  endtask

  task automatic test_skid_order();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    out_ready = 1'b0; in_valid = 1'b1; in_exc = 5'd0; local_exc = 5'd0;
    in_data = a; in_pc = 32'h100; cycle();
    in_data = b; in_pc = 32'h104; cycle();
    checks++; if (count1 !== 2'd2 || bus1.in_ready !== 1'b0) begin failures++; $display("FAIL skid_full got=%0d,%b exp=2,0", count1, bus1.in_ready); end
    in_data = c; in_pc = 32'h108; cycle();
    checks++; if (count1 !== 2'd2 || bus1.out_data !== a) begin failures++; $display("FAIL skid_hold got=%0d,%h exp=2,%h", count1, bus1.out_data, a); end
    out_ready = 1'b1; cycle();
    checks++; if (bus1.out_data !== b || bus1.out_pc !== 32'h104 || count1 !== 2'd1) begin failures++; $display("FAIL skid_pop_b got=%h,%h,%0d exp=%h,104,1", bus1.out_data, bus1.out_pc, count1, b); end
    cycle();
    in_valid = 1'b0;
    checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== c || count1 !== 2'd1) begin failures++; $display("FAIL skid_pop_c got=%b,%h,%0d exp=1,%h,1", bus1.out_valid, bus1.out_data, count1, c); end
    cycle();
    checks++; if (bus1.out_valid !== 1'b0 || count1 !== 2'd0) begin failures++; $display("FAIL skid_drain got=%b,%0d exp=0,0", bus1.out_valid, count1); end
    cycle();
  endtask

  task automatic test_exc_merge();
    out_ready = 1'b1; in_valid = 1'b1; in_data = $urandom; in_exc = 5'd4; local_exc = 5'd10;
    cycle();
    checks++; if (bus0.out_exc !== 5'd4 || bus1.out_exc !== 5'd4) begin failures++; $display("FAIL exc_older got=%0d/%0d exp=4", bus0.out_exc, bus1.out_exc); end
    in_exc = 5'd0; local_exc = 5'd12;
    cycle();
    checks++; if (bus0.out_exc !== 5'd12 || bus1.out_exc !== 5'd12) begin failures++; $display("FAIL exc_local got=%0d/%0d exp=12", bus0.out_exc, bus1.out_exc); end
    checks++; if (bus0.out_valid !== 1'b1 || bus1.out_valid !== 1'b1) begin failures++; $display("FAIL exc_flow got=%b/%b exp=1/1", bus0.out_valid, bus1.out_valid); end
    in_valid = 1'b0; local_exc = 5'd0;
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = $urandom; cycle();
    in_data = $urandom; cycle();
    checks++; if (count1 !== 2'd2) begin failures++; $display("FAIL flush_pre got=%0d exp=2", count1); end
    flush = 1'b1; in_data = $urandom; cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b/%b exp=0/0", bus0.out_valid, bus1.out_valid); end
    checks++; if (count0 !== 2'd0 || count1 !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d/%0d exp=0/0", count0, count1); end
    checks++; if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b/%b exp=1/1", bus0.in_ready, bus1.in_ready); end
    cycle();
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", bus1.out_valid); end
  endtask

  task automatic test_kill();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_pc = 32'h4000; in_exc = 5'd3;
    cycle();
    in_valid = 1'b0; in_exc = 5'd0;
    checks++; if (count1 !== 2'd1 || bus1.out_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL kill_pre got=%0d,%h exp=1,deadbeef", count1, bus1.out_data); end
    kill = 1'b1; cycle(); kill = 1'b0;
    checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin failures++; $display("FAIL kill_valid got=%b/%b exp=0/0", bus0.out_valid, bus1.out_valid); end
    checks++; if ({bus0.out_data, bus0.out_pc, bus0.out_exc} !== 69'd0) begin failures++; $display("FAIL kill_payload0 got=%h exp=0", {bus0.out_data, bus0.out_pc, bus0.out_exc}); end
    checks++; if ({bus1.out_data, bus1.out_pc, bus1.out_exc} !== 69'd0) begin failures++; $display("FAIL kill_payload1 got=%h exp=0", {bus1.out_data, bus1.out_pc, bus1.out_exc}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      in_valid = 1'b1; in_data = d; in_pc = 32'h2000 + 32'(i * 4);
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus0.in_ready); end
      cycle();
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== d) begin failures++; $display("FAIL b2b_out0 i=%0d got=%b,%h exp=1,%h", i, bus0.out_valid, bus0.out_data, d); end
      checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== d || count1 !== 2'd1) begin failures++; $display("FAIL b2b_out1 i=%0d got=%b,%h,%0d exp=1,%h,1", i, bus1.out_valid, bus1.out_data, count1, d); end
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/0", bus0.out_valid, bus1.out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_exc = 5'd7;
    in_data = $urandom; in_pc = $urandom; cycle();
    in_data = $urandom; cycle();
    reset = 1'b1; in_valid = 1'b1; cycle();
    reset = 1'b0; in_valid = 1'b0; in_exc = 5'd0;
    checks++; if (bus1.out_valid !== 1'b0 || count1 !== 2'd0 || {bus1.out_data, bus1.out_pc, bus1.out_exc} !== 69'd0) begin failures++; $display("FAIL reset_mid1 got=%b,%0d,%h exp=0,0,0", bus1.out_valid, count1, {bus1.out_data, bus1.out_pc, bus1.out_exc}); end
    checks++; if (bus0.out_valid !== 1'b0 || count0 !== 2'd0 || {bus0.out_data, bus0.out_pc, bus0.out_exc} !== 69'd0) begin failures++; $display("FAIL reset_mid0 got=%b,%0d,%h exp=0,0,0", bus0.out_valid, count0, {bus0.out_data, bus0.out_pc, bus0.out_exc}); end
    checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready got=%b exp=1", bus1.in_ready); end
  endtask

  task automatic test_random();
    ent_t exp0, exp1;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_pc     = $urandom;
      in_exc    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      local_exc = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      out_ready = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      kill      = ($urandom_range(0, 60) == 0);
      reset     = ($urandom_range(0, 150) == 0);
      #1;
      checks++; if (bus0.in_ready !== exp_rdy0()) begin failures++; $display("FAIL rnd_ready0 i=%0d got=%b exp=%b", i, bus0.in_ready, exp_rdy0()); end
      checks++; if (bus1.in_ready !== exp_rdy1()) begin failures++; $display("FAIL rnd_ready1 i=%0d got=%b exp=%b", i, bus1.in_ready, exp_rdy1()); end
      cycle();
      checks++; if (bus0.out_valid !== (q0.size() != 0) || count0 !== 2'(q0.size())) begin failures++; $display("FAIL rnd_occ0 i=%0d got=%b,%0d exp=%0d", i, bus0.out_valid, count0, q0.size()); end
      checks++; if (bus1.out_valid !== (q1.size() != 0) || count1 !== 2'(q1.size())) begin failures++; $display("FAIL rnd_occ1 i=%0d got=%b,%0d exp=%0d", i, bus1.out_valid, count1, q1.size()); end
      exp0 = (q0.size() != 0) ? q0[0] : hold0;
      exp1 = (q1.size() != 0) ? q1[0] : hold1;
      if (q0.size() != 0 || hk0) begin
        checks++; if ({bus0.out_data, bus0.out_pc, bus0.out_exc} !== exp0) begin failures++; $display("FAIL rnd_payload0 i=%0d got=%h exp=%h", i, {bus0.out_data, bus0.out_pc, bus0.out_exc}, exp0); end
      end
      if (q1.size() != 0 || hk1) begin
        checks++; if ({bus1.out_data, bus1.out_pc, bus1.out_exc} !== exp1) begin failures++; $display("FAIL rnd_payload1 i=%0d got=%h exp=%h", i, {bus1.out_data, bus1.out_pc, bus1.out_exc}, exp1); end
      end
    end
    reset = 1'b0; flush = 1'b0; kill = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_skid_order();
    test_exc_merge();
    test_flush();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
